// File: rtl/data_mem_controller_pkg.sv
// rtl/data_mem_controller_pkg.sv - shared READ_WRITE op codes and access-size decode
//
// Purpose: holds the EX/MEM READ_WRITE encodings as shared macros and the
// access-size type used by the load/store alignment logic.
// Ports: none (package).

`ifndef UTILS_MACROS_RW_CODES
`define UTILS_MACROS_RW_CODES
`define RW_IDLE 4'b0000
`define RW_LB   4'b1000
`define RW_LH   4'b1001
`define RW_LW   4'b1010
`define RW_LBU  4'b1100
`define RW_LHU  4'b1101
`define RW_SB   4'b0101
`define RW_SH   4'b0110
`define RW_SW   4'b0111
`endif

package data_mem_controller_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } access_size_t;

  // Funct3 values of the sign-extending and zero-extending narrow loads.
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_store_align.sv
// rtl/load_store_align.sv - combinational op decode, store lane steering, load extract/extend
//
// Purpose: decodes READ_WRITE into load/store/size, flags misaligned accesses,
// produces byte enables and replicated store data, and extracts/extends the
// loaded byte or halfword from the returned memory word.
// Ports:
//   read_write    in  4   live op code from EX/MEM
//   offset        in  2   live ADDRESS[1:0]
//   write_data    in  32  live store data
//   load_funct3   in  3   funct3 of the latched load
//   load_offset   in  2   ADDRESS[1:0] of the latched load
//   mem_read_data in  32  word returned by memory
//   is_load       out 1   live op is a valid load
//   is_store      out 1   live op is a valid store
//   misaligned    out 1   live op is a valid but misaligned access
//   byte_en       out 4   byte enables for the live op
//   store_data    out 32  lane-replicated store data
//   load_data     out 32  extended load result from mem_read_data

module load_store_align
  import data_mem_controller_pkg::*;
(
  input  logic [3:0]  read_write,
  input  logic [1:0]  offset,
  input  logic [31:0] write_data,
  input  logic [2:0]  load_funct3,
  input  logic [1:0]  load_offset,
  input  logic [31:0] mem_read_data,
  output logic        is_load,
  output logic        is_store,
  output logic        misaligned,
  output logic [3:0]  byte_en,
  output logic [31:0] store_data,
  output logic [31:0] load_data
);

  access_size_t size;
  logic [7:0]   lane_byte;
  logic [15:0]  lane_half;

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    size     = SZ_WORD;
    case (read_write)
      `RW_LB, `RW_LBU: begin is_load  = 1'b1; size = SZ_BYTE; end
      `RW_LH, `RW_LHU: begin is_load  = 1'b1; size = SZ_HALF; end
      `RW_LW:          begin is_load  = 1'b1; size = SZ_WORD; end
      `RW_SB:          begin is_store = 1'b1; size = SZ_BYTE; end
      `RW_SH:          begin is_store = 1'b1; size = SZ_HALF; end
      `RW_SW:          begin is_store = 1'b1; size = SZ_WORD; end
      default:         ;
    endcase

    misaligned = (is_load | is_store) &&
                 (((size == SZ_HALF) && offset[0]) ||
                  ((size == SZ_WORD) && (offset != 2'b00)));

    // Loads always fetch the whole word; the lane is picked on return.
    byte_en    = 4'b1111;
    store_data = write_data;
    if (is_store) begin
      case (size)
        SZ_BYTE: begin
          byte_en    = 4'b0001 << offset;
          store_data = {4{write_data[7:0]}};
        end
        SZ_HALF: begin
          byte_en    = 4'b0011 << {offset[1], 1'b0};
          store_data = {2{write_data[15:0]}};
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    lane_byte = mem_read_data[{load_offset, 3'b000} +: 8];
    lane_half = load_offset[1] ? mem_read_data[31:16] : mem_read_data[15:0];
    case (load_funct3)
      F3_LB:   load_data = {{24{lane_byte[7]}}, lane_byte};
      F3_LH:   load_data = {{16{lane_half[15]}}, lane_half};
      F3_LBU:  load_data = {24'h000000, lane_byte};
      F3_LHU:  load_data = {16'h0000, lane_half};
      default: load_data = mem_read_data;
    endcase
  end

endmodule

// File: rtl/data_mem_controller.sv
// rtl/data_mem_controller.sv - EX/MEM data-memory access sequencer with pipeline stall
//
// Purpose: runs the IDLE/ACCESS/DONE request-busywait handshake with the data
// memory for the op in EX/MEM and stalls the pipeline until it completes.
// Ports:
//   CLK, RESET (async, active-low)
//   READ_WRITE, ADDRESS, WRITE_DATA, HOLD     in   from EX/MEM / hazard logic
//   BUSYWAIT, READ_DATA, MISALIGNED           out  to pipeline / MEM/WB
//   MEM_READ, MEM_WRITE, MEM_ADDRESS,
//   MEM_WRITE_DATA, MEM_BYTE_EN               out  to data memory
//   MEM_READ_DATA, MEM_BUSYWAIT               in   from data memory

module data_mem_controller
  import data_mem_controller_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic [3:0]  READ_WRITE,
  input  logic [31:0] ADDRESS,
  input  logic [31:0] WRITE_DATA,
  input  logic        HOLD,
  output logic        BUSYWAIT,
  output logic [31:0] READ_DATA,
  output logic        MISALIGNED,
  output logic        MEM_READ,
  output logic        MEM_WRITE,
  output logic [29:0] MEM_ADDRESS,
  output logic [31:0] MEM_WRITE_DATA,
  output logic [3:0]  MEM_BYTE_EN,
  input  logic [31:0] MEM_READ_DATA,
  input  logic        MEM_BUSYWAIT
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t      state, state_next;
  logic        is_load, is_store, misaligned;
  logic [3:0]  byte_en;
  logic [31:0] store_data, load_data;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_offset;
  logic [31:0] read_data_q;
  logic        op_go, busy, mis_flag;

  load_store_align u_align (
    .read_write    (READ_WRITE),
    .offset        (ADDRESS[1:0]),
    .write_data    (WRITE_DATA),
    .load_funct3   (ld_funct3),
    .load_offset   (ld_offset),
    .mem_read_data (MEM_READ_DATA),
    .is_load       (is_load),
    .is_store      (is_store),
    .misaligned    (misaligned),
    .byte_en       (byte_en),
    .store_data    (store_data),
    .load_data     (load_data)
  );

  assign op_go = (is_load | is_store) & ~misaligned;

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    mis_flag   = 1'b0;
    case (state)
      IDLE: begin
        if (op_go) begin
          busy       = 1'b1;
          state_next = ACCESS;
        end else if (is_load | is_store) begin
          mis_flag = 1'b1;
        end
      end
      ACCESS: begin
        busy = 1'b1;
        if (!MEM_BUSYWAIT) state_next = DONE;
      end
      DONE: begin
        if (!HOLD) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // The combinational flags are masked so every output reads 0 while in reset.
  assign BUSYWAIT   = busy & RESET;
  assign MISALIGNED = mis_flag & RESET;
  assign READ_DATA  = MISALIGNED ? 32'h0 : read_data_q;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state          <= IDLE;
      MEM_READ       <= 1'b0;
      MEM_WRITE      <= 1'b0;
      MEM_ADDRESS    <= 30'h0;
      MEM_WRITE_DATA <= 32'h0;
      MEM_BYTE_EN    <= 4'h0;
      ld_funct3      <= 3'b000;
      ld_offset      <= 2'b00;
      read_data_q    <= 32'h0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (op_go) begin
            MEM_ADDRESS    <= ADDRESS[31:2];
            MEM_BYTE_EN    <= byte_en;
            MEM_WRITE_DATA <= store_data;
            MEM_READ       <= is_load;
            MEM_WRITE      <= is_store;
            ld_funct3      <= READ_WRITE[2:0];
            ld_offset      <= ADDRESS[1:0];
          end
        end
        ACCESS: begin
          if (!MEM_BUSYWAIT) begin
            MEM_READ  <= 1'b0;
            MEM_WRITE <= 1'b0;
            if (MEM_READ) read_data_q <= load_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_controller.sv
// tb/tb_data_mem_controller.sv - scoreboard bench for data_mem_controller

module tb_data_mem_controller;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [3:0]  READ_WRITE;
  logic [31:0] ADDRESS;
  logic [31:0] WRITE_DATA;
  logic        HOLD;
  logic        BUSYWAIT;
  logic [31:0] READ_DATA;
  logic        MISALIGNED;
  logic        MEM_READ;
  logic        MEM_WRITE;
  logic [29:0] MEM_ADDRESS;
  logic [31:0] MEM_WRITE_DATA;
  logic [3:0]  MEM_BYTE_EN;
  logic [31:0] MEM_READ_DATA;
  logic        MEM_BUSYWAIT;

  always #5 CLK = ~CLK;

  data_mem_controller dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .READ_WRITE     (READ_WRITE),
    .ADDRESS        (ADDRESS),
    .WRITE_DATA     (WRITE_DATA),
    .HOLD           (HOLD),
    .BUSYWAIT       (BUSYWAIT),
    .READ_DATA      (READ_DATA),
    .MISALIGNED     (MISALIGNED),
    .MEM_READ       (MEM_READ),
    .MEM_WRITE      (MEM_WRITE),
    .MEM_ADDRESS    (MEM_ADDRESS),
    .MEM_WRITE_DATA (MEM_WRITE_DATA),
    .MEM_BYTE_EN    (MEM_BYTE_EN),
    .MEM_READ_DATA  (MEM_READ_DATA),
    .MEM_BUSYWAIT   (MEM_BUSYWAIT)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [3:0]  rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          lat;
    logic [29:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wd;
    logic [31:0] e_rd;
    logic        e_wr;
    int          e_busy;
    int          e_req;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  // Memory model: holds MEM_BUSYWAIT high for lat_cfg cycles of a request,
  // then drops it while presenting rdata_cfg in the same cycle.
  int          lat_cfg   = 0;
  logic [31:0] rdata_cfg = 32'h0;
  int          cnt       = 0;

  initial begin
    MEM_BUSYWAIT  = 1'b0;
    MEM_READ_DATA = 32'h0;
    forever begin
      @(negedge CLK);
      #2;
      if (MEM_READ || MEM_WRITE) begin
        if (cnt > 0) begin
          MEM_BUSYWAIT = 1'b1;
          cnt--;
        end else begin
          MEM_BUSYWAIT  = 1'b0;
          MEM_READ_DATA = rdata_cfg;
        end
      end else begin
        cnt           = lat_cfg;
        MEM_BUSYWAIT  = 1'b0;
        MEM_READ_DATA = 32'h0;
      end
    end
  end

  // Drives one op at the current negedge and follows it until BUSYWAIT falls;
  // returns in the DONE cycle, after comparing against the scoreboard entry.
  task automatic run_op(input vec_t v);
    vec_t        e;
    int          busy = 0;
    int          reqc = 0;
    bit          seen = 0;
    bit          done = 0;
    logic [29:0] ga = '0;
    logic [3:0]  gb = '0;
    logic [31:0] gw = '0;
    logic [31:0] grd = '0;
    logic        gwr = 1'b0;
    READ_WRITE = v.rw;
    ADDRESS    = v.addr;
    WRITE_DATA = v.wdata;
    lat_cfg    = v.lat;
    rdata_cfg  = v.rdata;
    sb.push_back(v);
    for (int c = 0; c < 64 && !done; c++) begin
      #1;
      if (c == 0) check("misaligned_clear", 32'(MISALIGNED), 32'h0);
      if (BUSYWAIT) busy++;
      if (MEM_READ || MEM_WRITE) begin
        reqc++;
        if (!seen) begin
          seen = 1;
          ga   = MEM_ADDRESS;
          gb   = MEM_BYTE_EN;
          gw   = MEM_WRITE_DATA;
          gwr  = MEM_WRITE;
        end
      end
      if (!BUSYWAIT) begin
        done = 1;
        grd  = READ_DATA;
      end else begin
        @(negedge CLK);
      end
    end
    e = sb.pop_front();
    check("op_completed", 32'(done), 32'h1);
    check("busy_cycles", busy, e.e_busy);
    check("req_cycles", reqc, e.e_req);
    check("mem_address", {2'b00, ga}, {2'b00, e.e_addr});
    check("byte_en", {28'h0, gb}, {28'h0, e.e_be});
    check("req_is_write", 32'(gwr), 32'(e.e_wr));
    if (e.e_wr) check("mem_write_data", gw, e.e_wd);
    check("read_data", grd, e.e_rd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //            rw       addr        wdata        rdata       lat e_addr   e_be     e_wd          e_rd          wr  busy req
    vecs.push_back('{4'b1010, 32'h100, 32'h0,        32'hDEADBEEF, 0, 30'h40,  4'hF,    32'h0,        32'hDEADBEEF, 0,  2,   1});
    vecs.push_back('{4'b1000, 32'h103, 32'h0,        32'h80FF1234, 0, 30'h40,  4'hF,    32'h0,        32'hFFFFFF80, 0,  2,   1});
    vecs.push_back('{4'b1100, 32'h103, 32'h0,        32'h80FF1234, 0, 30'h40,  4'hF,    32'h0,        32'h00000080, 0,  2,   1});
    vecs.push_back('{4'b0110, 32'h202, 32'h0000ABCD, 32'h0,        3, 30'h80,  4'hC,    32'hABCDABCD, 32'h00000080, 1,  5,   4});
    vecs.push_back('{4'b1001, 32'h102, 32'h0,        32'h80FF1234, 1, 30'h40,  4'hF,    32'h0,        32'hFFFF80FF, 0,  3,   2});
    vecs.push_back('{4'b1101, 32'h100, 32'h0,        32'h80FF8234, 0, 30'h40,  4'hF,    32'h0,        32'h00008234, 0,  2,   1});
    vecs.push_back('{4'b0101, 32'h301, 32'h123456A5, 32'h0,        0, 30'hC0,  4'b0010, 32'hA5A5A5A5, 32'h00008234, 1,  2,   1});
    vecs.push_back('{4'b0111, 32'h404, 32'hCAFEF00D, 32'h0,        2, 30'h101, 4'hF,    32'hCAFEF00D, 32'h00008234, 1,  4,   3});
    vecs.push_back('{4'b1000, 32'h101, 32'h0,        32'h00007F00, 0, 30'h40,  4'hF,    32'h0,        32'h0000007F, 0,  2,   1});

    // Reset held with a valid LW on the inputs.
    RESET      = 1'b0;
    READ_WRITE = 4'b1010;
    ADDRESS    = 32'h100;
    WRITE_DATA = 32'h55;
    HOLD       = 1'b0;
    repeat (2) @(negedge CLK);
    #1;
    check("rst_busywait", 32'(BUSYWAIT), 32'h0);
    check("rst_misaligned", 32'(MISALIGNED), 32'h0);
    check("rst_mem_read", 32'(MEM_READ), 32'h0);
    check("rst_mem_write", 32'(MEM_WRITE), 32'h0);
    check("rst_mem_address", {2'b00, MEM_ADDRESS}, 32'h0);
    check("rst_mem_wdata", MEM_WRITE_DATA, 32'h0);
    check("rst_byte_en", {28'h0, MEM_BYTE_EN}, 32'h0);
    check("rst_read_data", READ_DATA, 32'h0);
    @(negedge CLK);
    RESET      = 1'b1;
    READ_WRITE = 4'b0000;
    @(negedge CLK);

    // Back-to-back ops: each new op is driven in the cycle right after DONE.
    foreach (vecs[i]) begin
      run_op(vecs[i]);
      @(negedge CLK);
    end
    READ_WRITE = 4'b0000;
    @(negedge CLK);

    // HOLD keeps DONE: no reissue, result stable.
    run_op('{4'b1010, 32'h100, 32'h0, 32'h11223344, 0, 30'h40, 4'hF, 32'h0, 32'h11223344, 0, 2, 1});
    HOLD = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge CLK);
      #1;
      check("hold_busywait", 32'(BUSYWAIT), 32'h0);
      check("hold_read_data", READ_DATA, 32'h11223344);
      check("hold_no_reissue", 32'(MEM_READ), 32'h0);
    end
    HOLD = 1'b0;
    @(negedge CLK);
    #1;
    check("hold_release_idle", 32'(BUSYWAIT), 32'h1);
    READ_WRITE = 4'b0000;
    #1;
    check("idle_no_op", 32'(BUSYWAIT), 32'h0);
    @(negedge CLK);

    // Misaligned accesses: flagged, no stall, no request.
    READ_WRITE = 4'b1010;
    ADDRESS    = 32'h102;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("mis_lw_flag", 32'(MISALIGNED), 32'h1);
      check("mis_lw_busy", 32'(BUSYWAIT), 32'h0);
      check("mis_lw_no_read", 32'(MEM_READ), 32'h0);
      check("mis_lw_read_data", READ_DATA, 32'h0);
      @(negedge CLK);
    end
    READ_WRITE = 4'b0110;
    ADDRESS    = 32'h201;
    #1;
    check("mis_sh_flag", 32'(MISALIGNED), 32'h1);
    @(negedge CLK);
    #1;
    check("mis_sh_no_write", 32'(MEM_WRITE), 32'h0);
    READ_WRITE = 4'b1101;
    ADDRESS    = 32'h103;
    #1;
    check("mis_lhu_flag", 32'(MISALIGNED), 32'h1);
    READ_WRITE = 4'b0000;
    #1;
    check("mis_clear_idle", 32'(MISALIGNED), 32'h0);
    check("read_data_after_mis", READ_DATA, 32'h11223344);
    @(negedge CLK);

    // Reset asserted mid-ACCESS drops the request without a clock edge.
    READ_WRITE = 4'b1010;
    ADDRESS    = 32'h500;
    lat_cfg    = 5;
    @(negedge CLK);
    #1;
    check("access_req_high", 32'(MEM_READ), 32'h1);
    #1;
    RESET = 1'b0;
    #1;
    check("rst_abort_read", 32'(MEM_READ), 32'h0);
    check("rst_abort_busy", 32'(BUSYWAIT), 32'h0);
    check("rst_abort_addr", {2'b00, MEM_ADDRESS}, 32'h0);
    @(negedge CLK);
    READ_WRITE = 4'b0000;
    lat_cfg    = 0;
    RESET      = 1'b1;
    repeat (2) @(negedge CLK);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
